// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO controller: default geometry,
// flag thresholds and the pointer width helper.
package fifo_pkg;

  localparam int ADDRSIZE_DEF = 3;
  localparam int DEPTH_DEF    = 1 << ADDRSIZE_DEF;
  localparam int AF_LEVEL_DEF = 6;
  localparam int AE_LEVEL_DEF = 2;

  // One extra wrap bit above the array index distinguishes full from empty.
  function automatic int ptr_w(input int addrsize);
    return addrsize + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer for one side of the FIFO: synchronous reset to zero,
// natural binary increment so index DEPTH-1 rolls to 0 and toggles the wrap bit.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inc,
  output logic [ptr_w(ADDRSIZE)-1:0]   ptr
);

  localparam int PW = ptr_w(ADDRSIZE);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: owns read/write pointers, occupancy and status
// flags, and sequences an external 8-bit storage array in first-word-fall-through mode.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AF_LEVEL = AF_LEVEL_DEF,
  parameter int AE_LEVEL = AE_LEVEL_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic                  rd_req,
  output logic                  mem_wr_en,
  output logic [ADDRSIZE-1:0]   mem_wr_addr,
  output logic [ADDRSIZE-1:0]   mem_rd_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDRSIZE:0]     count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int              PW      = ptr_w(ADDRSIZE);
  localparam logic [PW-1:0]   DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0]   AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0]   AE_C    = PW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_accept;
  logic          rd_accept;

  // Occupancy is the modular pointer distance, so it and every flag depend
  // only on registered pointers, never on the current requests.
  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_accept   = wr_req & ~full;
  assign rd_accept   = rd_req & ~empty;
  assign mem_wr_en   = wr_accept;
  assign mem_wr_addr = wr_ptr[ADDRSIZE-1:0];
  assign mem_rd_addr = rd_ptr[ADDRSIZE-1:0];

  fifo_ptr #(
    .ADDRSIZE (ADDRSIZE)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_accept),
    .ptr (wr_ptr)
  );

  fifo_ptr #(
    .ADDRSIZE (ADDRSIZE)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_accept),
    .ptr (rd_ptr)
  );

  // Error pulses flag the rejected request for exactly one following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_req & full;
      underflow <= rd_req & empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl with a behavioural storage array and a
// queue-based reference model of occupancy, flags and data order.
module tb_sync_fifo_ctrl;

  localparam int AS = 3;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          mem_wr_en;
  logic [AS-1:0] mem_wr_addr;
  logic [AS-1:0] mem_rd_addr;
  logic          full, empty, almost_full, almost_empty;
  logic [AS:0]   count;
  logic          overflow, underflow;
  logic [7:0]    rd_data;
  logic [7:0]    mem [D];

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .ADDRSIZE (AS),
    .DEPTH    (D),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_rd_addr  (mem_rd_addr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Storage array beside the controller: registered write, combinational read.
  always @(posedge clk) if (mem_wr_en) mem[mem_wr_addr] <= wr_data;
  assign rd_data = mem[mem_rd_addr];

  int         tests = 0;
  int         fails = 0;
  logic [7:0] mdl[$];
  logic [7:0] exp_rd[$];
  int         wr_n = 0;
  int         rd_n = 0;
  bit         exp_ovf = 1'b0;
  bit         exp_unf = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_status();
    int n;
    n = mdl.size();
    chk("count", int'(count), n);
    chk("empty", int'(empty), int'(n == 0));
    chk("full", int'(full), int'(n == D));
    chk("almost_full", int'(almost_full), int'(n >= AF));
    chk("almost_empty", int'(almost_empty), int'(n <= AE));
    chk("overflow", int'(overflow), int'(exp_ovf));
    chk("underflow", int'(underflow), int'(exp_unf));
    chk("mem_wr_addr", int'(mem_wr_addr), wr_n % D);
    chk("mem_rd_addr", int'(mem_rd_addr), rd_n % D);
  endtask

  task automatic step(input bit w, input bit r, input bit rs, input logic [7:0] d);
    bit wacc, racc, was_full, was_empty;
    @(negedge clk);
    check_status();
    wr_req  = w;
    rd_req  = r;
    rst     = rs;
    wr_data = d;
    was_full  = (mdl.size() == D);
    was_empty = (mdl.size() == 0);
    wacc = w && !was_full;
    racc = r && !was_empty;
    #1;
    chk("mem_wr_en", int'(mem_wr_en), int'(wacc));
    if (!rs && racc) exp_rd.push_back(mdl[0]);
    @(posedge clk);
    if (rs) begin
      mdl.delete();
      wr_n = 0;
      rd_n = 0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      exp_ovf = w && was_full;
      exp_unf = r && was_empty;
      if (racc) begin
        void'(mdl.pop_front());
        rd_n++;
      end
      if (wacc) begin
        mdl.push_back(d);
        wr_n++;
      end
    end
  endtask

  // Monitor: every accepted pop must present the oldest outstanding entry.
  always @(negedge clk) begin
    #2;
    if (!rst && rd_req && !empty) begin
      if (exp_rd.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_data: pop with no expected entry, got %0d", rd_data);
      end else begin
        chk("rd_data", int'(rd_data), int'(exp_rd.pop_front()));
      end
    end
  end

  initial begin
    int pw, pr;
    repeat (2) @(posedge clk);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 8'h10 + 8'(i));
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h20 + 8'(i));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 8'h30 + 8'(i));

    while (mdl.size() < D) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, 1'b0, 8'hAA);
    while (mdl.size() > 0) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h55);
    step(1'b0, 1'b1, 1'b0, 8'h00);

    while (mdl.size() < 5) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b0, 1'b1, 8'h77);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    for (int p = 0; p < 4; p++) begin
      pw = (p == 0) ? 70 : (p == 1) ? 30 : (p == 2) ? 50 : 90;
      pr = 100 - pw + 10;
      for (int i = 0; i < 120; i++) begin
        step($urandom_range(99) < pw, $urandom_range(99) < pr,
             $urandom_range(199) == 0, 8'($urandom));
      end
    end

    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("sb_drain", exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
